cache_ctrl_dm: RTL and testbench
================================

Name: cache_ctrl_dm

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller. One word per line.
- Sits between a CPU-side request/acknowledge port and a single-port backing RAM.
- The backing RAM has a registered read address: read data appears one cycle after the address is presented (addr/din/we/dout interface).
- This block is the initiator that drives that RAM.

Parameters:
- AWIDTH, 3, word address width of the CPU and memory buses.
- DWIDTH, 32, data width.
- IDX_W, 1, index bits. Lines = 1<<IDX_W. Tag width = AWIDTH-IDX_W; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request valid (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AWIDTH  word address. Index = cpu_addr[IDX_W-1:0], tag = upper bits.
- cpu_wdata  in  DWIDTH  write data.
- cpu_flush  in  1  invalidate all lines.
- cpu_ack  out  1  one-cycle completion pulse, registered.
- cpu_rdata  out  DWIDTH  read data, valid when cpu_ack=1, registered, held otherwise.
- mem_addr  out  AWIDTH  backing RAM address.
- mem_din  out  DWIDTH  backing RAM write data.
- mem_we  out  1  backing RAM write enable.
- mem_dout  in  DWIDTH  backing RAM read data, valid one cycle after mem_addr.
- hit_count  out  16  hit counter (optional feature).
- miss_count  out  16  miss counter (optional feature).

Behaviour:
- Clock and reset: one clock, clock. reset_n is asynchronous, active-low.
- Reset: state=IDLE, all valid bits=0, cpu_ack=0, cpu_rdata=0, captured addr/data/we=0, counters=0. Tag and data arrays need no reset.
- Memory-side outputs are combinational from state and captured registers:
  - mem_addr = captured addr, mem_din = captured wdata.
  - mem_we = 1 only in COMPARE with a captured write; 0 in all other states.
- IDLE:
  - cpu_flush=1: clear all valid bits at the clock edge; stay IDLE; no ack. Flush has priority over cpu_req in the same cycle.
  - Otherwise, cpu_req=1: capture cpu_addr, cpu_we and cpu_wdata, then go to COMPARE.
- COMPARE (hit = valid[idx] && tag[idx]==captured tag):
  - Read hit: cpu_rdata<=data[idx], cpu_ack<=1, go to IDLE. Latency: ack visible 2 cycles after the req sample edge.
  - Read miss: mem_addr is presented this cycle; go to FILL.
  - Write: mem_we=1 this cycle.
    - On hit, data[idx]<=wdata.
    - On miss, the cache is unchanged (no allocate).
    - cpu_ack<=1, cpu_rdata unchanged, go to IDLE.
- FILL: mem_dout is valid this cycle.
  - Update the line: data[idx]<=mem_dout, tag[idx]<=captured tag, valid[idx]<=1.
  - cpu_rdata<=mem_dout, cpu_ack<=1, go to IDLE. Read-miss latency: 3 cycles.
- cpu_ack is high exactly one cycle, and that cycle is spent in IDLE.
  - cpu_req high during the ack cycle is taken as a new request (back-to-back allowed).
  - The requester holds cpu_req and request fields stable until ack. Changes while busy are ignored because the fields are captured.
- cpu_flush outside IDLE is ignored.
- Reset asserted mid-operation: immediate return to IDLE. mem_we drops combinationally, the pending ack is never issued, valid bits are cleared.
- The same address in consecutive requests needs no special case: a write-hit updates the line before the next COMPARE.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_count increments on each read or write hit in COMPARE.
  - miss_count increments on each read or write miss in COMPARE.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset and on flush.
- Undefined: both ports are tied to 0, and no counter logic is generated.

Test Plan:
- Setup for all cases: AWIDTH=3, IDX_W=1, memory preloaded mem[i]=i*0x11.
- Reset, then read addr 5:
  - Cycle 1 after sample: mem_addr=5, mem_we=0.
  - cpu_ack at cycle 3 with cpu_rdata=0x55.
  - miss_count=1.
- Read addr 5 again: ack at cycle 2, rdata=0x55, mem_we stays 0, hit_count=1.
- Write addr 5 = 0xDEAD:
  - mem_we=1 for exactly one cycle with mem_addr=5, mem_din=0xDEAD.
  - Ack at cycle 2.
  - A following read of 5 hits and returns 0xDEAD.
- Read addr 3 (same index, tag 1): miss, returns 0x33, evicts line. Then read 5: miss, returns 0xDEAD from memory.
- Write-miss addr 2 = 0x1234: memory written, no allocate. Read 2 then misses (3-cycle ack) and returns 0x1234.
- Flush, then read 5: miss. In a separate run, assert reset_n=0 during FILL: no ack, mem_we=0, and the next read 5 misses.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller, one word
// per line, driving a single-port RAM with a one-cycle registered read.
// Optional feature macro: CACHE_STATS_EN (hit/miss counters; tied to 0 when undefined).
module cache_ctrl_dm #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int IDX_W  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_ack,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = AWIDTH - IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DWIDTH-1:0] data_arr [LINES];

  logic [AWIDTH-1:0] cap_addr;
  logic [DWIDTH-1:0] cap_wdata;
  logic              cap_we;

  logic [IDX_W-1:0]  cap_idx;
  logic [TAG_W-1:0]  cap_tag;
  logic              hit;
  logic              take_req;
  logic              do_flush;

  assign cap_idx  = cap_addr[IDX_W-1:0];
  assign cap_tag  = cap_addr[AWIDTH-1:IDX_W];
  assign hit      = valid[cap_idx] && (tag_arr[cap_idx] == cap_tag);
  // Flush wins over a simultaneous request and is only honoured in IDLE.
  assign do_flush = (state == IDLE) && cpu_flush;
  assign take_req = (state == IDLE) && !cpu_flush && cpu_req;

  // The RAM always sees the captured request; only the write strobe depends on state.
  assign mem_addr = cap_addr;
  assign mem_din  = cap_wdata;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and write strobe: writes go through to RAM in COMPARE, hit or miss.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (take_req) state_nxt = COMPARE;
      end
      COMPARE: begin
        mem_we = cap_we;
        if (cap_we || hit) state_nxt = IDLE;
        else               state_nxt = FILL;
      end
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields so the requester's later changes cannot disturb a transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
    end else if (take_req) begin
      cap_addr  <= cpu_addr;
      cap_wdata <= cpu_wdata;
      cap_we    <= cpu_we;
    end
  end

  // Valid bits: cleared by reset or flush, set when a fill completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              valid          <= '0;
    else if (do_flush)         valid          <= '0;
    else if (state == FILL)    valid[cap_idx] <= 1'b1;
  end

  // Tag/data arrays: write-hit updates data in place, fill loads tag and data.
  always_ff @(posedge clock) begin
    if (state == COMPARE && cap_we && hit) begin
      data_arr[cap_idx] <= cap_wdata;
    end else if (state == FILL) begin
      data_arr[cap_idx] <= mem_dout;
      tag_arr[cap_idx]  <= cap_tag;
    end
  end

  // Registered acknowledge and read data; rdata holds between acks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (state == COMPARE) begin
        if (cap_we) begin
          cpu_ack <= 1'b1;
        end else if (hit) begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= data_arr[cap_idx];
        end
      end else if (state == FILL) begin
        cpu_ack   <= 1'b1;
        cpu_rdata <= mem_dout;
      end
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating hit/miss counters, classified in COMPARE, cleared by reset or flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (do_flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm with a registered-read RAM model and a
// queue of expected read data consumed on each cpu_ack.
module tb_cache_ctrl_dm;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_flush;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [2:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic [15:0] hit_count, miss_count;

  logic [31:0] mem [8] = '{32'h00, 32'h11, 32'h22, 32'h33,
                           32'h44, 32'h55, 32'h66, 32'h77};

  int          checks = 0;
  int          passes = 0;
  logic [31:0] sb_q [$];
  logic [31:0] last_rd = '0;

  cache_ctrl_dm #(.AWIDTH(3), .DWIDTH(32), .IDX_W(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered read address.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_stats(input string tag, input int h, input int m);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"},   {16'h0, hit_count},  32'(h));
    chk({tag, "_misses"}, {16'h0, miss_count}, 32'(m));
`else
    chk({tag, "_hits"},   {16'h0, hit_count},  32'h0);
    chk({tag, "_misses"}, {16'h0, miss_count}, 32'h0);
`endif
  endtask

  // One request: expected rdata pushed at issue, popped and compared at ack.
  task automatic xact(input string tag, input logic we, input logic [2:0] a,
                      input logic [31:0] wd, input int exp_lat, input int exp_wec);
    int          lat;
    int          wec;
    logic [31:0] exp_rd;
    lat = 0;
    wec = 0;
    @(negedge clock);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    if (we) sb_q.push_back(last_rd);
    else    sb_q.push_back(mem[a]);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) chk({tag, "_addr_c1"}, {29'h0, mem_addr}, {29'h0, a});
      if (mem_we) begin
        wec++;
        chk({tag, "_we_addr"}, {29'h0, mem_addr}, {29'h0, a});
        chk({tag, "_we_din"}, mem_din, wd);
      end
      if (cpu_ack) begin
        lat = c;
        break;
      end
    end
    cpu_req = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_we_cycles"}, 32'(wec), 32'(exp_wec));
    if (lat != 0 && sb_q.size() != 0) begin
      exp_rd = sb_q.pop_front();
      chk({tag, "_rdata"}, cpu_rdata, exp_rd);
      last_rd = exp_rd;
    end
    sb_q.delete();
    @(negedge clock);
    chk({tag, "_ack_1cyc"}, {31'h0, cpu_ack}, 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_flush = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_ack",   {31'h0, cpu_ack}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_addr",  {29'h0, mem_addr}, 32'h0);
    chk_stats("rst", 0, 0);
    reset_n = 1'b1;

    xact("rd5_miss", 1'b0, 3'd5, 32'h0, 3, 0);
    chk_stats("rd5_miss", 0, 1);
    xact("rd5_hit", 1'b0, 3'd5, 32'h0, 2, 0);
    chk_stats("rd5_hit", 1, 1);
    xact("wr5_hit", 1'b1, 3'd5, 32'hDEAD, 2, 1);
    chk_stats("wr5_hit", 2, 1);
    xact("rd5_after_wr", 1'b0, 3'd5, 32'h0, 2, 0);
    chk_stats("rd5_after_wr", 3, 1);
    xact("rd3_evict", 1'b0, 3'd3, 32'h0, 3, 0);
    xact("rd5_refill", 1'b0, 3'd5, 32'h0, 3, 0);
    chk("rd5_refill_val", cpu_rdata, 32'hDEAD);
    chk_stats("rd5_refill", 3, 3);
    xact("wr2_miss", 1'b1, 3'd2, 32'h1234, 2, 1);
    chk_stats("wr2_miss", 3, 4);
    xact("rd2_noalloc", 1'b0, 3'd2, 32'h0, 3, 0);
    chk("rd2_val", cpu_rdata, 32'h1234);

    // Flush together with a request: flush wins, no ack.
    @(negedge clock);
    cpu_flush = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 3'd5;
    @(negedge clock);
    cpu_flush = 1'b0;
    cpu_req   = 1'b0;
    chk("flush_no_ack0", {31'h0, cpu_ack}, 32'h0);
    @(negedge clock);
    chk("flush_no_ack1", {31'h0, cpu_ack}, 32'h0);
    chk_stats("flush", 0, 0);
    xact("rd5_after_flush", 1'b0, 3'd5, 32'h0, 3, 0);
    chk_stats("rd5_after_flush", 0, 1);

    // Reset during FILL of a read miss on address 3.
    @(negedge clock);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 3'd3;
    @(negedge clock);
    chk("rstfill_cmp_addr", {29'h0, mem_addr}, 32'h3);
    @(negedge clock);
    chk("rstfill_in_fill_ack", {31'h0, cpu_ack}, 32'h0);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rstfill_we", {31'h0, mem_we}, 32'h0);
    chk("rstfill_ack", {31'h0, cpu_ack}, 32'h0);
    @(negedge clock);
    chk("rstfill_ack_held", {31'h0, cpu_ack}, 32'h0);
    chk("rstfill_rdata", cpu_rdata, 32'h0);
    reset_n = 1'b1;
    last_rd = '0;
    @(negedge clock);
    chk("rstfill_no_late_ack", {31'h0, cpu_ack}, 32'h0);
    xact("rd5_after_rst", 1'b0, 3'd5, 32'h0, 3, 0);
    chk("rd5_after_rst_val", cpu_rdata, 32'hDEAD);
    chk_stats("rd5_after_rst", 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
